// File: rtl/noc_route_requester.sv
// Route-request initiator: asks the Q-learning engine for a route and streams its 3-bit hop codes.
// Optional statistics outputs are enabled with `define ROUTE_REQ_STATS_EN.
module noc_route_requester #(
  parameter int MAX_HOPS    = 10,
  parameter int HOP_W       = 3,
  parameter int NODE_MAX    = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pkt_valid,
  input  logic [4:0]                pkt_src,
  input  logic [4:0]                pkt_dst,
  output logic                      pkt_ready,
  input  logic                      Q_learn_ready,
  output logic                      ReqRoute,
  output logic [9:0]                Sor_DesInfo,
  input  logic                      enroute,
  input  logic [MAX_HOPS*HOP_W-1:0] RouteInfoIn,
  output logic                      hop_valid,
  output logic [HOP_W-1:0]          hop_dir,
  output logic                      hop_last,
  input  logic                      hop_ready,
  output logic                      route_err
`ifdef ROUTE_REQ_STATS_EN
  ,
  output logic [15:0]               stat_req_cnt,
  output logic [7:0]                stat_tmo_cnt,
  output logic [7:0]                stat_err_cnt
`endif
);

  localparam int RW  = MAX_HOPS * HOP_W;
  localparam int K_W = (MAX_HOPS > 1) ? $clog2(MAX_HOPS) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_RDY  = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_EMIT      = 3'd4;

  logic [2:0]       state, state_n;
  logic             pkt_ready_q;
  logic             route_err_q, err_set;
  logic [7:0]       tmo_cnt, tmo_cnt_n;
  logic [K_W-1:0]   hop_k, hop_k_n;
  logic [4:0]       src_q, dst_q;
  logic [RW-1:0]    route_q, route_sh;
  logic [HOP_W-1:0] cur_code;
  logic             code_ok, cur_last, accept, bad_id;

  assign accept   = pkt_valid & pkt_ready_q;
  assign bad_id   = (pkt_src > 5'(NODE_MAX)) | (pkt_dst > 5'(NODE_MAX));
  assign route_sh = route_q >> (HOP_W * hop_k);
  assign cur_code = route_sh[HOP_W-1:0];
  assign code_ok  = (cur_code <= HOP_W'(4));
  // A zero code is the eject hop, so it always terminates the stream.
  assign cur_last = (cur_code == '0) | (hop_k == K_W'(MAX_HOPS - 1));

  always_comb begin
    state_n   = state;
    err_set   = 1'b0;
    tmo_cnt_n = tmo_cnt;
    hop_k_n   = hop_k;
    case (state)
      S_IDLE: begin
        tmo_cnt_n = '0;
        hop_k_n   = '0;
        if (accept) begin
          if (bad_id)                 err_set = 1'b1;
          else if (pkt_src == pkt_dst) state_n = S_EMIT;
          else                        state_n = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: if (Q_learn_ready) state_n = S_REQ;
      S_REQ: begin
        state_n   = S_WAIT_RESP;
        tmo_cnt_n = '0;
      end
      S_WAIT_RESP: begin
        // A response arriving on the final wait cycle still beats the timeout.
        if (enroute) begin
          state_n   = S_EMIT;
          tmo_cnt_n = '0;
          hop_k_n   = '0;
        end else if (tmo_cnt == 8'(TIMEOUT_CYC - 1)) begin
          state_n   = S_IDLE;
          err_set   = 1'b1;
          tmo_cnt_n = '0;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
      end
      S_EMIT: begin
        if (!code_ok) begin
          state_n = S_IDLE;
          err_set = 1'b1;
        end else if (hop_ready) begin
          if (cur_last) state_n = S_IDLE;
          else          hop_k_n = hop_k + K_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      pkt_ready_q <= 1'b0;
      route_err_q <= 1'b0;
      tmo_cnt     <= '0;
      hop_k       <= '0;
    end else begin
      state       <= state_n;
      pkt_ready_q <= (state_n == S_IDLE);
      route_err_q <= err_set;
      tmo_cnt     <= tmo_cnt_n;
      hop_k       <= hop_k_n;
    end
  end

  // Payload registers carry no reset; every output that exposes them is gated by state.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && accept) begin
      src_q   <= pkt_src;
      dst_q   <= pkt_dst;
      route_q <= '0;
    end else if (state == S_WAIT_RESP && enroute) begin
      route_q <= RouteInfoIn;
    end
  end

  assign pkt_ready   = pkt_ready_q;
  assign route_err   = route_err_q;
  assign ReqRoute    = (state == S_REQ);
  assign Sor_DesInfo = (state == S_REQ || state == S_WAIT_RESP) ? {src_q, dst_q} : '0;
  assign hop_valid   = (state == S_EMIT) & code_ok;
  assign hop_dir     = hop_valid ? cur_code : '0;
  assign hop_last    = hop_valid & cur_last;

`ifdef ROUTE_REQ_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_req_cnt <= '0;
      stat_tmo_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (state == S_REQ)                  stat_req_cnt <= sat_inc16(stat_req_cnt);
      if (err_set && state == S_WAIT_RESP) stat_tmo_cnt <= sat_inc8(stat_tmo_cnt);
      if (err_set)                         stat_err_cnt <= sat_inc8(stat_err_cnt);
    end
  end
`endif

endmodule
